bp_fetch_pc_gen: RTL and testbench

//   Parametrised next-PC generator for the fetch stage: holds the fetch PC, predicts the next one via a

---
 rtl/bp_fetch_pc_gen_pkg.sv | 32 +++
 rtl/bp_fetch_pc_gen_if.sv | 29 ++
 rtl/bp_fetch_pc_gen_btb.sv | 125 ++++++++++++
 rtl/bp_fetch_pc_gen.sv | 69 ++++++
 tb/tb_bp_fetch_pc_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_fetch_pc_gen_pkg.sv
// Shared helpers for the fetch next-PC generator: index sizing and
// saturating branch-counter encodings/arithmetic.
package bp_fetch_pc_gen_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set (e.g. 2'b01).
  function automatic int ctr_wnt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Weakly-taken: MSB set, all lower bits clear (e.g. 2'b10).
  function automatic int ctr_wt(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int sat_inc(input int c, input int w);
    return (c == (1 << w) - 1) ? c : c + 1;
  endfunction

  function automatic int sat_dec(input int c);
    return (c == 0) ? c : c - 1;
  endfunction

endpackage

// File: rtl/bp_fetch_pc_gen_if.sv
// Fetch-side bundle: stall/redirect/training inputs and the PC/prediction outputs.
interface bp_fetch_pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              redirect_done;

  modport master (
    output fetch_stall, redirect_valid, redirect_target,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  fetch_pc, pred_hit, pred_taken, pred_target, redirect_done
  );

  modport slave (
    input  fetch_stall, redirect_valid, redirect_target,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output fetch_pc, pred_hit, pred_taken, pred_target, redirect_done
  );
endinterface

// File: rtl/bp_fetch_pc_gen_btb.sv
// Direct-mapped BTB: one combinational lookup port, one registered training port.
// With BP_UPDATE_BYPASS_EN defined, a same-index update is forwarded to the lookup.
module bp_fetch_pc_gen_btb
  import bp_fetch_pc_gen_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);
  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];

  logic [IDX_W-1:0] upd_idx, lk_idx;
  logic [TAG_W-1:0] upd_tag, lk_tag;
  logic             upd_hit;
  logic             wr_en;
  logic [ADDR_W-1:0] wr_target;
  logic [CTR_W-1:0]  wr_ctr;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [ADDR_W-1:0] rd_target;
  logic [CTR_W-1:0]  rd_ctr;
  logic              unused_pc_lsbs;

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{upd_pc[1:0], lk_pc[1:0]};

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Post-update contents of the indexed entry; not-taken misses leave it alone.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = target_q[upd_idx];
    wr_ctr    = ctr_q[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_ctr    = CTR_W'(sat_inc(int'(ctr_q[upd_idx]), CTR_W));
          wr_target = upd_target;
        end else begin
          wr_ctr = CTR_W'(sat_dec(int'(ctr_q[upd_idx])));
        end
      end else if (upd_taken) begin
        wr_en     = 1'b1;
        wr_target = upd_target;
        wr_ctr    = CTR_W'(ctr_wt(CTR_W));
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (wr_en) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = wr_target;
      ctr_d[upd_idx]    = wr_ctr;
    end
  end

  // Reset wins over any pending update, so training during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_W'(ctr_wnt(CTR_W));
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  always_comb begin
    rd_valid  = valid_q[lk_idx];
    rd_tag    = tag_q[lk_idx];
    rd_target = target_q[lk_idx];
    rd_ctr    = ctr_q[lk_idx];
`ifdef BP_UPDATE_BYPASS_EN
    if (wr_en && (upd_idx == lk_idx)) begin
      rd_valid  = 1'b1;
      rd_tag    = upd_tag;
      rd_target = wr_target;
      rd_ctr    = wr_ctr;
    end
`endif
  end

  assign lk_hit    = rd_valid && (rd_tag == lk_tag);
  assign lk_taken  = lk_hit && rd_ctr[CTR_W-1];
  assign lk_target = rd_target;

endmodule

// File: rtl/bp_fetch_pc_gen.sv
// Fetch next-PC generator: registered fetch PC, BTB prediction, late redirects.
// Optional same-cycle update forwarding is enabled by defining BP_UPDATE_BYPASS_EN.
module bp_fetch_pc_gen
  import bp_fetch_pc_gen_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                BTB_ENTRIES = 16,
  parameter int                CTR_W       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input logic              clk,
  input logic              rst,
  bp_fetch_pc_gen_if.slave bus
);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              redirect_done_q, redirect_done_d;
  logic              btb_hit, btb_taken;
  logic [ADDR_W-1:0] btb_target;
  logic [ADDR_W-1:0] pred_target;

  bp_fetch_pc_gen_btb #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES),
    .CTR_W   (CTR_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (fetch_pc_q),
    .lk_hit     (btb_hit),
    .lk_taken   (btb_taken),
    .lk_target  (btb_target),
    .upd_valid  (bus.upd_valid),
    .upd_pc     (bus.upd_pc),
    .upd_taken  (bus.upd_taken),
    .upd_target (bus.upd_target)
  );

  // Sequential path wraps naturally at the top of the address space.
  assign pred_target = btb_taken ? btb_target : fetch_pc_q + ADDR_W'(4);

  // Redirect outranks stall so a redirect arriving while fetch is stalled still lands.
  always_comb begin
    fetch_pc_d      = pred_target;
    redirect_done_d = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d      = bus.redirect_target;
      redirect_done_d = 1'b1;
    end else if (bus.fetch_stall) begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q      <= RESET_PC;
      redirect_done_q <= 1'b0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      redirect_done_q <= redirect_done_d;
    end
  end

  assign bus.fetch_pc      = fetch_pc_q;
  assign bus.pred_hit      = btb_hit;
  assign bus.pred_taken    = btb_taken;
  assign bus.pred_target   = pred_target;
  assign bus.redirect_done = redirect_done_q;

endmodule

// File: tb/tb_bp_fetch_pc_gen.sv
// Directed bench for bp_fetch_pc_gen (16-entry BTB, 2-bit counters, reset PC 0).
module tb_bp_fetch_pc_gen;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bp_fetch_pc_gen_if #(.ADDR_W(32)) bus ();

  bp_fetch_pc_gen #(
    .ADDR_W      (32),
    .BTB_ENTRIES (16),
    .CTR_W       (2),
    .RESET_PC    (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt);
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
  endtask

  task automatic set_redir(input logic v, input logic [31:0] tgt);
    bus.redirect_valid  = v;
    bus.redirect_target = tgt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.fetch_stall = 1'b0;
    set_redir(1'b0, 32'h0);
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();

    // Reset state
    chk("rst_fetch_pc", bus.fetch_pc, 32'h0);
    chk("rst_redirect_done", 32'(bus.redirect_done), 32'h0);
    chk("rst_pred_hit", 32'(bus.pred_hit), 32'h0);
    chk("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    rst = 1'b0;

    // Empty BTB: sequential fetch
    chk("seq_pred_target0", bus.pred_target, 32'h4);
    step();
    chk("seq_pc4", bus.fetch_pc, 32'h4);
    step();
    chk("seq_pc8", bus.fetch_pc, 32'h8);
    chk("seq_hit8", 32'(bus.pred_hit), 32'h0);
    chk("seq_rdone8", 32'(bus.redirect_done), 32'h0);

    // Allocate 0x10 -> 0x40 while redirecting back to 0 in the same cycle
    set_upd(1'b1, 32'h10, 1'b1, 32'h40);
    set_redir(1'b1, 32'h0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    set_redir(1'b0, 32'h0);
    chk("redir0_pc", bus.fetch_pc, 32'h0);
    chk("redir0_done", 32'(bus.redirect_done), 32'h1);
    step();
    chk("after_redir_done_low", 32'(bus.redirect_done), 32'h0);
    step();
    step();
    step();
    chk("alloc_pc10", bus.fetch_pc, 32'h10);
    chk("alloc_hit", 32'(bus.pred_hit), 32'h1);
    chk("alloc_taken", 32'(bus.pred_taken), 32'h1);
    chk("alloc_target", bus.pred_target, 32'h40);
    step();
    chk("taken_next_pc", bus.fetch_pc, 32'h40);

    // Aliasing: 0x50 shares index 4 with 0x10 but has a different tag
    set_redir(1'b1, 32'h50);
    step();
    set_redir(1'b0, 32'h0);
    chk("alias_pc", bus.fetch_pc, 32'h50);
    chk("alias_hit", 32'(bus.pred_hit), 32'h0);
    chk("alias_target", bus.pred_target, 32'h54);
    step();

    // Three not-taken updates: 10 -> 01 -> 00 -> 00 (saturates low)
    for (int i = 0; i < 3; i++) begin
      set_upd(1'b1, 32'h10, 1'b0, 32'h0);
      step();
    end
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk("nt_run_pc", bus.fetch_pc, 32'h60);
    set_redir(1'b1, 32'h10);
    step();
    set_redir(1'b0, 32'h0);
    chk("nt_pc10", bus.fetch_pc, 32'h10);
    chk("nt_hit", 32'(bus.pred_hit), 32'h1);
    chk("nt_taken", 32'(bus.pred_taken), 32'h0);
    chk("nt_target", bus.pred_target, 32'h14);

    // Hold at 0x10 and retrain; counter 00 -> 01 -> 10 -> 11 -> 11
    bus.fetch_stall = 1'b1;
    set_upd(1'b1, 32'h10, 1'b1, 32'h80);
    chk("tr1_taken_same", 32'(bus.pred_taken), 32'h0);
    step();
    chk("stall_hold_pc", bus.fetch_pc, 32'h10);
    chk("tr1_taken_next", 32'(bus.pred_taken), 32'h0);
`ifdef BP_UPDATE_BYPASS_EN
    chk("tr2_taken_same", 32'(bus.pred_taken), 32'h1);
    chk("tr2_target_same", bus.pred_target, 32'h80);
`else
    chk("tr2_taken_same", 32'(bus.pred_taken), 32'h0);
    chk("tr2_target_same", bus.pred_target, 32'h14);
`endif
    step();
    chk("tr2_taken_next", 32'(bus.pred_taken), 32'h1);
    chk("tr2_target_next", bus.pred_target, 32'h80);
    step();
    step();

    // From saturated 11: first not-taken -> 10 (still taken), second -> 01
    set_upd(1'b1, 32'h10, 1'b0, 32'h0);
    chk("sat_nt1_same", 32'(bus.pred_taken), 32'h1);
    step();
    chk("sat_nt1_next", 32'(bus.pred_taken), 32'h1);
`ifdef BP_UPDATE_BYPASS_EN
    chk("sat_nt2_same", 32'(bus.pred_taken), 32'h0);
    chk("sat_nt2_target_same", bus.pred_target, 32'h14);
`else
    chk("sat_nt2_same", 32'(bus.pred_taken), 32'h1);
    chk("sat_nt2_target_same", bus.pred_target, 32'h80);
`endif
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat_nt2_next", 32'(bus.pred_taken), 32'h0);
    chk("sat_hold_pc", bus.fetch_pc, 32'h10);
    bus.fetch_stall = 1'b0;
    step();
    chk("release_pc", bus.fetch_pc, 32'h14);

    // Redirect during stall wins
    bus.fetch_stall = 1'b1;
    set_redir(1'b1, 32'h200);
    step();
    set_redir(1'b0, 32'h0);
    chk("stall_redir_pc", bus.fetch_pc, 32'h200);
    chk("stall_redir_done", 32'(bus.redirect_done), 32'h1);
    step();
    chk("stall_redir_hold", bus.fetch_pc, 32'h200);
    chk("stall_redir_done_low", 32'(bus.redirect_done), 32'h0);
    bus.fetch_stall = 1'b0;
    step();
    chk("stall_redir_seq", bus.fetch_pc, 32'h204);

    // Wrap at the top of the address space
    set_redir(1'b1, 32'hFFFF_FFFC);
    step();
    set_redir(1'b0, 32'h0);
    chk("wrap_pred_target", bus.pred_target, 32'h0);
    step();
    chk("wrap_pc", bus.fetch_pc, 32'h0);

    // Reset mid-run clears BTB and drops the concurrent update
    rst = 1'b1;
    set_upd(1'b1, 32'h20, 1'b1, 32'h300);
    step();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst2_pc", bus.fetch_pc, 32'h0);
    set_redir(1'b1, 32'h10);
    step();
    chk("rst2_cleared_hit", 32'(bus.pred_hit), 32'h0);
    set_redir(1'b1, 32'h20);
    step();
    set_redir(1'b0, 32'h0);
    chk("rst2_dropped_hit", 32'(bus.pred_hit), 32'h0);
    chk("rst2_dropped_target", bus.pred_target, 32'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
